// File: rtl/axil_led_pwm_ctrl_if.sv
// AXI4-Lite bus bundle between an AXI master (interconnect) and the LED controller.
// Carries the AW, W, B, AR and R channels; clock and reset stay outside the interface.
interface axil_led_pwm_ctrl_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_led_pwm_ctrl.sv
// AXI4-Lite LED controller: NUM_LEDS channels, each off / static / PWM-dimmed / blinking,
// driven from a shared prescaler, PWM counter and blink divider.
// Ports: ACLK, ARESETN (async active-low), s_axi (AXI4-Lite slave), led_o (registered LED drive, 1 = on).
module axil_led_pwm_ctrl #(
    parameter int unsigned NUM_LEDS           = 8,
    parameter int unsigned PWM_WIDTH          = 8,
    parameter int unsigned PRESC_WIDTH        = 16,
    parameter int unsigned BLINK_DIV          = 64,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axil_led_pwm_ctrl_if.slave   s_axi,
    output logic [NUM_LEDS-1:0]  led_o
);
    localparam int unsigned DATA_W    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned WORD_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned DUTY_BASE = 4;
    localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

    // Configuration registers
    logic                      ctrl_en;
    logic [PRESC_WIDTH-1:0]    presc;
    logic [2*NUM_LEDS-1:0]     mode;
    logic [NUM_LEDS-1:0]       static_lvl;
    logic [PWM_WIDTH-1:0]      duty [NUM_LEDS];

    // Timebase
    logic [PRESC_WIDTH-1:0]    presc_cnt;
    logic [PWM_WIDTH-1:0]      pwm_cnt;
    logic [BLINK_W-1:0]        blink_cnt;
    logic                      blink_phase;

    // Bus state
    wr_state_t                 wr_state, wr_state_n;
    rd_state_t                 rd_state, rd_state_n;
    logic                      aw_rdy_q, aw_rdy_n;
    logic                      bvalid_q, bvalid_n;
    logic [1:0]                bresp_q, bresp_n;
    logic                      ar_rdy_q, ar_rdy_n;
    logic                      rvalid_q, rvalid_n;
    logic [DATA_W-1:0]         rdata_q, rdata_n;
    logic [1:0]                rresp_q, rresp_n;

    logic [WORD_W-1:0]         wr_word, rd_word;
    logic                      wr_fire_c, rd_fire_c, wr_hit_c, rd_hit_c, cnt_clr_c;
    logic [DATA_W-1:0]         wr_cur_c, rd_data_c, wr_mask_c, wr_merged_c;
    logic                      tick_c, pwm_wrap_c;
    logic [NUM_LEDS-1:0]       led_n;

    assign s_axi.awready = aw_rdy_q;
    assign s_axi.wready  = aw_rdy_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = ar_rdy_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign wr_word = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_word = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // Register map decode: {hit, read value} for a word address
    function automatic logic [DATA_W:0] reg_lookup(input logic [WORD_W-1:0] w);
        logic [DATA_W:0] res;
        res = '0;
        if (w == WORD_W'(0))      res = {1'b1, DATA_W'(ctrl_en)};
        else if (w == WORD_W'(1)) res = {1'b1, DATA_W'(presc)};
        else if (w == WORD_W'(2)) res = {1'b1, DATA_W'(mode)};
        else if (w == WORD_W'(3)) res = {1'b1, DATA_W'(static_lvl)};
        else begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (w == WORD_W'(DUTY_BASE + i)) res = {1'b1, DATA_W'(duty[i])};
            end
        end
        return res;
    endfunction

    // Address decode and byte-strobe merge for the pending write
    always_comb begin
        {wr_hit_c, wr_cur_c}  = reg_lookup(wr_word);
        {rd_hit_c, rd_data_c} = reg_lookup(rd_word);
        wr_mask_c = '0;
        for (int unsigned b = 0; b < DATA_W/8; b++) begin
            wr_mask_c[8*b +: 8] = {8{s_axi.wstrb[b]}};
        end
        wr_merged_c = (wr_cur_c & ~wr_mask_c) | (s_axi.wdata & wr_mask_c);
    end

    // Write channel FSM: registered AW/W ready pulse, then hold B until accepted
    always_comb begin
        wr_state_n = wr_state;
        aw_rdy_n   = 1'b0;
        bvalid_n   = bvalid_q;
        bresp_n    = bresp_q;
        wr_fire_c  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_rdy_q) begin
                    if (s_axi.awvalid && s_axi.wvalid) begin
                        wr_fire_c  = 1'b1;
                        bvalid_n   = 1'b1;
                        bresp_n    = wr_hit_c ? RESP_OKAY : RESP_SLVERR;
                        wr_state_n = W_RESP;
                    end
                end else if (s_axi.awvalid && s_axi.wvalid) begin
                    aw_rdy_n = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_n   = 1'b0;
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    // Read channel FSM: registered AR ready pulse, data captured at the handshake
    always_comb begin
        rd_state_n = rd_state;
        ar_rdy_n   = 1'b0;
        rvalid_n   = rvalid_q;
        rdata_n    = rdata_q;
        rresp_n    = rresp_q;
        rd_fire_c  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (ar_rdy_q) begin
                    if (s_axi.arvalid) begin
                        rd_fire_c  = 1'b1;
                        rvalid_n   = 1'b1;
                        rdata_n    = rd_hit_c ? rd_data_c : '0;
                        rresp_n    = rd_hit_c ? RESP_OKAY : RESP_SLVERR;
                        rd_state_n = R_DATA;
                    end
                end else if (s_axi.arvalid) begin
                    ar_rdy_n = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    rvalid_n   = 1'b0;
                    rd_state_n = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            wr_state <= wr_state_n;
            rd_state <= rd_state_n;
            aw_rdy_q <= aw_rdy_n;
            bvalid_q <= bvalid_n;
            bresp_q  <= bresp_n;
            ar_rdy_q <= ar_rdy_n;
            rvalid_q <= rvalid_n;
            rdata_q  <= rdata_n;
            rresp_q  <= rresp_n;
        end
    end

    // Register file update; unmapped writes fall through untouched
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en    <= 1'b0;
            presc      <= '0;
            mode       <= '0;
            static_lvl <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
        end else if (wr_fire_c && wr_hit_c) begin
            if (wr_word == WORD_W'(0))      ctrl_en    <= wr_merged_c[0];
            else if (wr_word == WORD_W'(1)) presc      <= wr_merged_c[PRESC_WIDTH-1:0];
            else if (wr_word == WORD_W'(2)) mode       <= wr_merged_c[2*NUM_LEDS-1:0];
            else if (wr_word == WORD_W'(3)) static_lvl <= wr_merged_c[NUM_LEDS-1:0];
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (wr_word == WORD_W'(DUTY_BASE + i)) duty[i] <= wr_merged_c[PWM_WIDTH-1:0];
            end
        end
    end

    // CNT_CLR is never stored: it acts on the counters at the write handshake itself
    assign cnt_clr_c  = wr_fire_c && wr_hit_c && (wr_word == WORD_W'(0))
                        && s_axi.wstrb[0] && s_axi.wdata[1];
    // >= so that lowering PRESC below the running count ticks immediately
    assign tick_c     = (presc_cnt >= presc);
    assign pwm_wrap_c = tick_c && (pwm_cnt == '1);

    // Shared timebase: prescaler -> PWM counter -> blink divider
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!ctrl_en || cnt_clr_c) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc_cnt <= tick_c ? '0 : presc_cnt + PRESC_WIDTH'(1);
            if (tick_c) pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            if (pwm_wrap_c) begin
                if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    // Per-channel output select
    always_comb begin
        led_n = '0;
        if (ctrl_en) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                case (mode[2*i +: 2])
                    2'b01:   led_n[i] = static_lvl[i];
                    2'b10:   led_n[i] = (pwm_cnt < duty[i]) || (duty[i] == '1);
                    2'b11:   led_n[i] = blink_phase;
                    default: led_n[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) led_o <= '0;
        else          led_o <= led_n;
    end
endmodule

// File: tb/tb_axil_led_pwm_ctrl.sv
// Self-checking bench for axil_led_pwm_ctrl: queued expected bus responses checked by a
// monitor, register model updated from the register-map rules, LED timing from arithmetic.
module tb_axil_led_pwm_ctrl;
    localparam int unsigned NL = 8;
    localparam int unsigned BD = 2;
    localparam int unsigned NREGS = 4 + NL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] led;

    always #5 clk = ~clk;

    axil_led_pwm_ctrl_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    axil_led_pwm_ctrl #(
        .NUM_LEDS(NL), .PWM_WIDTH(8), .PRESC_WIDTH(16), .BLINK_DIV(BD),
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .s_axi(bus.slave), .led_o(led)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;
    bit stall_b = 1'b0;
    bit stall_r = 1'b0;
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] mdl [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] reg_mask(input int w);
        if (w == 0) return 32'h1;
        if (w == 1 || w == 2) return 32'hFFFF;
        if (w < int'(NREGS)) return 32'hFF;
        return 32'h0;
    endfunction

    // Response ready drivers: random back-pressure unless stalled
    initial begin
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.bready = !stall_b && ($urandom_range(0, 3) != 0);
            bus.rready = !stall_r && ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every accepted response must match the oldest queued expectation
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.bvalid && bus.bready) begin
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_b: got bresp %0d expected no response", bus.bresp);
                    end else begin
                        chk("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
                    end
                end
                if (bus.rvalid && bus.rready) begin
                    if (exp_r.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_r: got rdata 0x%0h expected no response", bus.rdata);
                    end else begin
                        e = exp_r.pop_front();
                        chk("rdata", bus.rdata, e[33:2]);
                        chk("rresp", 32'(bus.rresp), 32'(e[1:0]));
                    end
                end
            end
        end
    end

    // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW
    task automatic axi_write(input int a, input logic [31:0] d, input logic [3:0] s, input int skew);
        logic [31:0] bm;
        int w;
        bit ok;
        int n;
        w = (a >> 2) & 31;
        if (w < int'(NREGS)) begin
            for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{s[b]}};
            mdl[w] = ((mdl[w] & ~bm) | (d & bm)) & reg_mask(w);
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
        n = (skew < 0) ? -skew : skew;
        @(posedge clk); #1;
        bus.awaddr = 7'(a);
        bus.wdata  = d;
        bus.wstrb  = s;
        if (skew >= 0) bus.awvalid = 1'b1;
        else           bus.wvalid  = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("single_channel_not_accepted", 32'(bus.awready | bus.wready), 32'h0);
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.awready && bus.wready) begin
                ok = 1'b1;
                last_hs = cyc + 1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL aw_w_handshake_timeout: got no ready expected ready within 20 cycles");
            void'(exp_b.pop_back());
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        chk("awready_single_pulse", 32'(bus.awready), 32'h0);
        for (int k = 0; k < 300 && exp_b.size() != 0; k++) @(negedge clk);
        if (exp_b.size() != 0) begin
            total++; bad++;
            $display("FAIL b_timeout: got %0d pending expected 0", exp_b.size());
            exp_b.delete();
        end
    endtask

    task automatic axi_read(input int a);
        int w;
        bit ok;
        w = (a >> 2) & 31;
        if (w < int'(NREGS)) exp_r.push_back({mdl[w], 2'b00});
        else                 exp_r.push_back({32'h0, 2'b10});
        @(posedge clk); #1;
        bus.araddr  = 7'(a);
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL ar_handshake_timeout: got no arready expected arready within 20 cycles");
            void'(exp_r.pop_back());
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        for (int k = 0; k < 300 && exp_r.size() != 0; k++) @(negedge clk);
        if (exp_r.size() != 0) begin
            total++; bad++;
            $display("FAIL r_timeout: got %0d pending expected 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    task automatic read_all();
        for (int w = 0; w < int'(NREGS); w++) axi_read(w * 4);
    endtask

    task automatic wait_led(input int idx, input logic val, output int at);
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (led[idx] === val) begin at = cyc; break; end
        end
        if (at < 0) begin
            total++; bad++;
            $display("FAIL led_wait_timeout: led[%0d] got no %0b expected %0b within 2000 cycles", idx, val, val);
            at = 0;
        end
    endtask

    task automatic wait_after_hs();
        while (cyc < last_hs + 1) @(negedge clk);
    endtask

    // PWM on led[0]: high count over one period and period repetition
    task automatic pwm_check(input int duty, input int exp_high);
        logic s [512];
        int hi, diff;
        axi_write(16, 32'(duty), 4'hF, 0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            s[k] = led[0];
        end
        hi = 0; diff = 0;
        for (int k = 0; k < 256; k++) begin
            if (s[k]) hi++;
            if (s[k] !== s[k + 256]) diff++;
        end
        chk($sformatf("pwm_high_count_duty%0d", duty), 32'(hi), 32'(exp_high));
        chk($sformatf("pwm_period_duty%0d", duty), 32'(diff), 32'h0);
    endtask

    initial begin
        int t0, t1, t2, hi;
        int a, op, skew;
        bit ok;

        for (int w = 0; w < 32; w++) mdl[w] = '0;
        rst_n = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'h0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'h0);
        chk("rst_arready", 32'(bus.arready), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        rst_n = 1'b1;
        read_all();

        // Register read/write
        axi_write(4, 32'hA5A5, 4'hF, 0);
        axi_write(8, 32'h0000FFFF, 4'hF, 2);
        for (int i = 0; i < int'(NL); i++) axi_write(16 + 4 * i, 32'(i + 1), 4'hF, -1);
        read_all();

        // Byte strobes
        axi_write(4, 32'h1234, 4'hF, 0);
        axi_write(4, 32'hABCD, 4'b0001, 0);
        chk("wstrb_model", mdl[1], 32'h12CD);
        axi_read(4);

        // Unmapped accesses
        axi_write(32'h7C, 32'hFFFFFFFF, 4'hF, 0);
        axi_write(32'h50, 32'hFFFFFFFF, 4'hF, 1);
        axi_read(32'h7C);
        axi_read(32'h53);
        read_all();

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 127));
            else a = int'($urandom_range(0, NREGS - 1)) * 4 + int'($urandom_range(0, 3));
            skew = int'($urandom_range(0, 6)) - 3;
            if (op == 0) axi_write(a, $urandom, 4'($urandom_range(0, 15)), skew);
            else         axi_read(a);
        end
        read_all();

        // Back-pressure: AW 3 cycles ahead of W, B held off
        stall_b = 1'b1;
        fork
            axi_write(12, 32'h5A, 4'hF, 3);
            begin
                repeat (14) @(negedge clk);
                chk("bvalid_held_under_stall", 32'(bus.bvalid), 32'h1);
                chk("b_not_consumed_under_stall", 32'(exp_b.size()), 32'h1);
                stall_b = 1'b0;
            end
        join
        stall_r = 1'b1;
        fork
            axi_read(12);
            begin
                repeat (12) @(negedge clk);
                chk("rvalid_held_under_stall", 32'(bus.rvalid), 32'h1);
                chk("rdata_held_under_stall", bus.rdata, 32'h5A);
                stall_r = 1'b0;
            end
        join

        // PWM
        axi_write(8, 32'h2, 4'hF, 0);
        axi_write(4, 32'h0, 4'hF, 0);
        axi_write(0, 32'h1, 4'hF, 0);
        pwm_check(64, 64);
        pwm_check(0, 0);
        pwm_check(255, 256);

        // Blink on led[1], static on led[2], CNT_CLR and EN behaviour
        axi_write(8, 32'h1C, 4'hF, 0);
        axi_write(12, 32'h04, 4'hF, 0);
        axi_write(0, 32'h3, 4'hF, 0);
        t0 = last_hs;
        wait_led(1, 1'b1, t1);
        chk("blink_first_rise", 32'(t1 - t0), 32'd513);
        wait_led(1, 1'b0, t2);
        chk("blink_half_period_high", 32'(t2 - t1), 32'd512);
        wait_led(1, 1'b1, t1);
        chk("blink_half_period_low", 32'(t1 - t2), 32'd512);
        hi = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (led[2]) hi++;
        end
        chk("static_led_steady", 32'(hi), 32'd300);
        axi_write(0, 32'h3, 4'hF, 0);
        t0 = last_hs;
        wait_after_hs();
        chk("cnt_clr_phase_low", 32'(led[1]), 32'h0);
        wait_led(1, 1'b1, t1);
        chk("cnt_clr_restart_rise", 32'(t1 - t0), 32'd513);
        axi_write(0, 32'h0, 4'hF, 0);
        wait_after_hs();
        chk("en_off_led_zero", 32'(led), 32'h0);
        axi_write(0, 32'h1, 4'hF, 0);
        t0 = last_hs;
        wait_led(1, 1'b1, t1);
        chk("en_restart_rise", 32'(t1 - t0), 32'd513);
        chk("static_on_before_reset", 32'(led[2]), 32'h1);

        // Reset in the middle of a write response
        stall_b = 1'b1;
        @(posedge clk); #1;
        bus.awaddr = 7'h04; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.awready) begin ok = 1'b1; break; end
        end
        chk("mid_write_accepted", 32'(ok), 32'h1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        chk("mid_write_bvalid_pending", 32'(bus.bvalid), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_bvalid", 32'(bus.bvalid), 32'h0);
        chk("reset_clears_led", 32'(led), 32'h0);
        stall_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 32; w++) mdl[w] = '0;
        read_all();
        repeat (5) @(negedge clk);
        chk("led_zero_after_reset", 32'(led), 32'h0);

        chk("b_queue_drained", 32'(exp_b.size()), 32'h0);
        chk("r_queue_drained", 32'(exp_r.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
